joy_shiftreg_responder: RTL and testbench

- Device-side end of the serial joystick link: emulates the 16-bit parallel-in/serial-out shift-register chain on the joystick board.
- Answers the joystick decoder's joy_load_n / joy_clk strobes with serial data on joy_data.
- Used as the responder in an FPGA-based joystick adapter, and as a synthesizable bus-functional model for decoder benches.
- Takes active-high button states, filters the incoming strobes, and drives active-low button bits MSB-first.

---
 rtl/joy_shiftreg_responder.sv | 114 +++++++++++
 tb/tb_joy_shiftreg_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/joy_shiftreg_responder.sv
// Device-side emulation of a 16-bit PISO joystick shift-register chain.
// Filters the decoder's load/clock strobes and shifts active-low buttons out MSB-first.
module joy_shiftreg_responder #(
    parameter int unsigned NBITS       = 16,
    parameter int unsigned FILTER_LEN  = 2,
    parameter int unsigned IDLE_CYCLES = 1400000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       joy_clk,
    input  logic       joy_load_n,
    output logic       joy_data,
    input  logic [7:0] joy1_btn,
    input  logic [7:0] joy2_btn,
    output logic       frame_done,
    output logic       link_idle
);

    localparam int unsigned IdleW = $clog2(IDLE_CYCLES + 1);

    // Strobe index: 0 = joy_clk, 1 = joy_load_n
    logic [1:0] pin;
    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic [1:0] filt_q;
    logic [1:0] filt_prev_q;
    logic [2:0] stab_cnt_q [2];

    logic             clk_rise;
    logic             load_fall;
    logic             load_active;
    logic [NBITS-1:0] load_vec;
    logic [NBITS-1:0] sr_q;
    logic [4:0]       bit_cnt_q;
    logic             frame_done_q;
    logic [IdleW-1:0] idle_cnt_q;
    logic [IdleW-1:0] idle_cnt_d;
    logic             link_idle_q;

    assign pin = {joy_load_n, joy_clk};

    // Synchronizer plus stability filter: the accepted level follows the synchronized
    // level only after it has differed for FILTER_LEN consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q      <= 2'b11;
            sync_q      <= 2'b11;
            filt_q      <= 2'b11;
            filt_prev_q <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                stab_cnt_q[i] <= 3'd0;
            end
        end else begin
            meta_q      <= pin;
            sync_q      <= meta_q;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] != filt_q[i]) begin
                    if (stab_cnt_q[i] + 3'd1 == 3'(FILTER_LEN)) begin
                        filt_q[i]     <= sync_q[i];
                        stab_cnt_q[i] <= 3'd0;
                    end else begin
                        stab_cnt_q[i] <= stab_cnt_q[i] + 3'd1;
                    end
                end else begin
                    stab_cnt_q[i] <= 3'd0;
                end
            end
        end
    end

    assign clk_rise    = filt_q[0] & ~filt_prev_q[0];
    assign load_fall   = ~filt_q[1] & filt_prev_q[1];
    assign load_active = ~filt_q[1];
    assign load_vec    = ~{joy1_btn, joy2_btn};

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (load_fall) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IdleW'(IDLE_CYCLES)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q         <= '1;
            bit_cnt_q    <= 5'd0;
            frame_done_q <= 1'b0;
            idle_cnt_q   <= '0;
            link_idle_q  <= 1'b1;
        end else begin
            // Load is transparent while held low and masks any coincident clock edge
            if (load_active) begin
                sr_q      <= load_vec;
                bit_cnt_q <= 5'd0;
            end else if (clk_rise) begin
                sr_q <= {sr_q[NBITS-2:0], 1'b1};
                if (bit_cnt_q != 5'(NBITS)) begin
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                end
            end
            frame_done_q <= ~load_active & clk_rise & (bit_cnt_q == 5'(NBITS - 1));
            idle_cnt_q   <= idle_cnt_d;
            link_idle_q  <= (idle_cnt_d == IdleW'(IDLE_CYCLES));
        end
    end

    assign joy_data   = sr_q[NBITS-1];
    assign frame_done = frame_done_q;
    assign link_idle  = link_idle_q;

endmodule

// File: tb/tb_joy_shiftreg_responder.sv
// Scoreboard bench for joy_shiftreg_responder: the driver queues expected values,
// a negedge monitor pops and compares them against joy_data, link_idle and frame count.
module tb_joy_shiftreg_responder;

    logic       clk;
    logic       rst_n;
    logic       joy_clk;
    logic       joy_load_n;
    logic       joy_data;
    logic [7:0] joy1_btn;
    logic [7:0] joy2_btn;
    logic       frame_done;
    logic       link_idle;

    joy_shiftreg_responder #(
        .NBITS      (16),
        .FILTER_LEN (2),
        .IDLE_CYCLES(100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .joy_clk   (joy_clk),
        .joy_load_n(joy_load_n),
        .joy_data  (joy_data),
        .joy1_btn  (joy1_btn),
        .joy2_btn  (joy2_btn),
        .frame_done(frame_done),
        .link_idle (link_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind 0: joy_data, 1: link_idle, 2: number of frame_done pulses so far
    typedef struct {
        int    kind;
        int    exp;
        string name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic chk_req;
    int   fd_cnt;
    int   total;
    int   bad;
    int   act;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (chk_req) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_underflow: no expected entry queued");
            end else begin
                mon_e = exp_q.pop_front();
                case (mon_e.kind)
                    0:       act = int'(joy_data);
                    1:       act = int'(link_idle);
                    default: act = fd_cnt;
                endcase
                if (act != mon_e.exp) begin
                    bad++;
                    $display("FAIL %s: got %0d expected %0d", mon_e.name, act, mon_e.exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input int kind, input int exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
        chk_req = 1'b1;
        @(posedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic do_load();
        joy_load_n = 1'b0;
        tick(6);
        joy_load_n = 1'b1;
        tick(6);
    endtask

    // One frame of nclk joy_clk pulses (8 cycles each); joy_data is read just before
    // each rising edge. Optional mid-frame button change and single-cycle glitches.
    task automatic run_frame(input logic [15:0] expv, input int nclk, input string tag,
                             input int chg_at, input logic [7:0] chg_val,
                             input int gclk_at, input int gload_at);
        for (int i = 0; i < nclk; i++) begin
            if (i == chg_at) joy1_btn = chg_val;
            joy_clk = 1'b0;
            tick(3);
            if (i == gclk_at) begin
                joy_clk = 1'b1;
                tick(1);
                joy_clk = 1'b0;
                tick(4);
            end
            if (i == gload_at) begin
                joy_load_n = 1'b0;
                tick(1);
                joy_load_n = 1'b1;
                tick(4);
            end
            check(0, (i < 16) ? int'(expv[15-i]) : 1, $sformatf("%s_bit%0d", tag, i));
            joy_clk = 1'b1;
            tick(4);
        end
        tick(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        total      = 0;
        bad        = 0;
        fd_cnt     = 0;
        chk_req    = 1'b0;
        rst_n      = 1'b0;
        joy_clk    = 1'b1;
        joy_load_n = 1'b1;
        joy1_btn   = 8'h00;
        joy2_btn   = 8'h00;

        // Reset state and quiet release with both strobes high
        tick(3);
        check(1, 1, "reset_link_idle");
        check(0, 1, "reset_joy_data");
        rst_n = 1'b1;
        tick(8);
        check(0, 1, "release_joy_data");
        check(2, 0, "release_no_frame");

        // joy1 = up+start pressed: L = {7E, FF}
        joy1_btn = 8'h81;
        joy2_btn = 8'h00;
        do_load();
        run_frame(16'h7EFF, 16, "f81", -1, 8'h00, -1, -1);
        check(2, 1, "f81_frame_done_once");

        // Buttons change mid-frame: frame in flight unaffected, next frame picks it up
        joy1_btn = 8'h00;
        joy2_btn = 8'h5A;
        do_load();
        run_frame(16'hFFA5, 16, "midchg", 5, 8'hFF, -1, -1);
        check(2, 2, "midchg_frame_done");
        do_load();
        run_frame(16'h00A5, 16, "next", -1, 8'h00, -1, -1);
        check(2, 3, "next_frame_done");

        // Single-cycle glitches on both strobes must be ignored; the joy1 change would
        // show if the load glitch were accepted.
        joy1_btn = 8'h18;
        joy2_btn = 8'hC3;
        do_load();
        run_frame(16'hE73C, 16, "glitch", 3, 8'h00, 9, 6);
        check(2, 4, "glitch_frame_done");

        // Clock edge while load is low is discarded; 20 clocks give trailing 1s, one pulse
        joy1_btn   = 8'h80;
        joy2_btn   = 8'h01;
        joy_load_n = 1'b0;
        tick(6);
        joy_clk = 1'b0;
        tick(4);
        joy_clk = 1'b1;
        tick(6);
        joy_load_n = 1'b1;
        tick(6);
        run_frame(16'h7FFE, 20, "over", -1, 8'h00, -1, -1);
        check(2, 5, "over_frame_done_once");

        // Idle: saturated, drops exactly 5 cycles after the pin edge, returns after 100
        tick(110);
        check(1, 1, "idle_saturated");
        joy_load_n = 1'b0;
        tick(4);
        check(1, 1, "idle_before_accept");
        check(1, 0, "idle_drop");
        joy_load_n = 1'b1;
        tick(98);
        check(1, 0, "idle_cnt_99");
        check(1, 1, "idle_cnt_100");

        tick(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
